apb_master_bridge: RTL and testbench

- Upstream neighbour of the APB slave memory: a single-outstanding APB requester.
- Turns a simple valid/ready request port (from testbench driver or CPU-side logic) into compliant APB SETUP/ACCESS sequences toward slave select PSEL1.
- Returns one response pulse per transfer with read data and error status.
- Guards against a hung slave with a wait-state timeout.

---
 rtl/apb_master_bridge_if.sv | 49 ++++
 rtl/apb_master_bridge.sv | 125 ++++++++++++
 tb/tb_apb_master_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - request/response and APB signal bundle for apb_master_bridge
// Purpose: groups the requester-side valid/ready port, the response port and
//          the APB requester signals so the bridge and its environment share one bundle.
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : request handshake and fields
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout          : one-cycle response pulse and held status
//   PSEL1/PENABLE/PWRITE/PADDR/PWDATA                : APB requester outputs
//   PREADY/PRDATA/PSLVERR                            : APB completer returns
// Modports: master = bridge side, slave = environment (request driver + APB completer).
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL1;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready to APB requester bridge
// Purpose: accepts one request at a time, runs an APB SETUP/ACCESS sequence on PSEL1,
//          and returns a one-cycle response pulse with read data and error status.
//          An ACCESS phase that stalls for TIMEOUT cycles is aborted.
// Ports:
//   PCLK   : clock, rising edge
//   PRESET : asynchronous active-high reset
//   bus    : apb_master_bridge_if.master (request, response and APB signals)
// Parameters: ADDR_W, DATA_W widths; TIMEOUT = max ACCESS cycles (0 = never abort).
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_bridge_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter only ever needs to reach TIMEOUT-1.
  localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
  localparam bit              TO_EN     = (TIMEOUT != 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          pwrite_d = bus.req_write;
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_write ? bus.req_wdata : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        // PREADY is deliberately not looked at here.
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        // Completion is tested first so PREADY on the threshold edge still wins.
        if (bus.PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.PSLVERR;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (TO_EN && (wait_cnt_q == LAST_WAIT)) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and select lines decode straight from the state register, so an
  // asynchronous reset drops them in the same instant.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.PSEL1       = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE     = (state_q == ACCESS);
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
  localparam int TO = 16;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  // One record per accepted transfer; timing derived from accept cycle a,
  // slave wait states w and resulting ACCESS length n.
  typedef struct {
    int          a;
    int          n;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    bit          err;
    int          w;
    bit          srdy;
    bit          to;
  } rec_t;

  rec_t        recs[$];
  rec_t        nr;
  int          cyc;
  int          acc_cnt;
  int          acc_a;
  int          v_w;
  logic [31:0] v_prdata;
  bit          v_err;
  bit          v_srdy;
  int          total;
  int          bad;
  int          obs_psel, obs_pen, obs_rsp_cnt, obs_rsp_cyc;
  logic [31:0] obs_rdata;
  bit          obs_err, obs_to;
  logic [31:0] m_rdata;
  bit          m_err, m_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit busy_at(input int c);
    foreach (recs[i])
      if (c >= recs[i].a + 1 && c <= recs[i].a + 1 + recs[i].n) return 1'b1;
    return 1'b0;
  endfunction

  // Model: acceptance at rising edges.
  initial forever begin
    @(posedge PCLK);
    if (PRESET) begin
      recs.delete();
      cyc = 0;
    end else begin
      if (bus.req_valid && !busy_at(cyc)) begin
        nr.a      = cyc;
        nr.wr     = bus.req_write;
        nr.addr   = bus.req_addr;
        nr.wdata  = bus.req_write ? bus.req_wdata : 32'h0;
        nr.prdata = v_prdata;
        nr.err    = v_err;
        nr.w      = v_w;
        nr.srdy   = v_srdy;
        if (v_w >= TO) begin
          nr.n  = TO;
          nr.to = 1'b1;
        end else begin
          nr.n  = v_w + 1;
          nr.to = 1'b0;
        end
        recs.push_back(nr);
        acc_cnt++;
        acc_a = cyc;
      end
      cyc++;
    end
  end

  // Compare every cycle on the falling edge, then drive the APB completer.
  initial forever begin
    bit          e_psel, e_pen, e_rv, rdy, e;
    logic [31:0] d, ea, ed;
    bit          ew;
    int          k;
    @(negedge PCLK);
    if (PRESET) begin
      m_rdata = 32'h0; m_err = 1'b0; m_to = 1'b0;
      bus.PREADY = 1'b0; bus.PRDATA = 32'h0; bus.PSLVERR = 1'b0;
    end else begin
      e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
      foreach (recs[i]) begin
        if (cyc >= recs[i].a + 1 && cyc <= recs[i].a + 1 + recs[i].n) e_psel = 1'b1;
        if (cyc >= recs[i].a + 2 && cyc <= recs[i].a + 1 + recs[i].n) e_pen = 1'b1;
        if (cyc == recs[i].a + 2 + recs[i].n) begin
          e_rv    = 1'b1;
          m_rdata = (recs[i].to || recs[i].wr) ? 32'h0 : recs[i].prdata;
          m_err   = recs[i].to ? 1'b1 : recs[i].err;
          m_to    = recs[i].to;
        end
      end
      if (recs.size() > 0) begin
        ea = recs[$].addr; ew = recs[$].wr; ed = recs[$].wdata;
      end else begin
        ea = 32'h0; ew = 1'b0; ed = 32'h0;
      end
      chk("psel",        bus.PSEL1,       e_psel);
      chk("penable",     bus.PENABLE,     e_pen);
      chk("req_ready",   bus.req_ready,   !e_psel);
      chk("rsp_valid",   bus.rsp_valid,   e_rv);
      chk("rsp_rdata",   bus.rsp_rdata,   m_rdata);
      chk("rsp_err",     bus.rsp_err,     m_err);
      chk("rsp_timeout", bus.rsp_timeout, m_to);
      chk("paddr",       bus.PADDR,       ea);
      chk("pwrite",      bus.PWRITE,      ew);
      chk("pwdata",      bus.PWDATA,      ed);
      if (bus.PSEL1)   obs_psel++;
      if (bus.PENABLE) obs_pen++;
      if (bus.rsp_valid) begin
        obs_rsp_cnt++;
        obs_rsp_cyc = cyc;
        obs_rdata   = bus.rsp_rdata;
        obs_err     = bus.rsp_err;
        obs_to      = bus.rsp_timeout;
      end
      rdy = 1'b0; d = 32'hBAD0BAD0; e = 1'b1;
      foreach (recs[i]) begin
        if (cyc == recs[i].a + 1) rdy = recs[i].srdy;
        if (cyc >= recs[i].a + 2 && cyc <= recs[i].a + 1 + recs[i].n) begin
          k = cyc - (recs[i].a + 2);
          if (k >= recs[i].w) begin
            rdy = 1'b1; d = recs[i].prdata; e = recs[i].err;
          end
        end
      end
      bus.PREADY = rdy; bus.PRDATA = d; bus.PSLVERR = e;
    end
  end

  task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int w, input logic [31:0] prd, input bit err, input bit srdy);
    int start;
    int k;
    start = acc_cnt;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    v_w = w; v_prdata = prd; v_err = err; v_srdy = srdy;
    k = 0;
    while (acc_cnt == start && k < 50) begin
      @(negedge PCLK);
      k++;
    end
    chk("accepted", acc_cnt != start, 1'b1);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(recs.size() > 0 && cyc >= recs[$].a + 3 + recs[$].n) && k < 100) begin
      @(negedge PCLK);
      k++;
    end
    chk("done", k < 100, 1'b1);
  endtask

  task automatic clear_obs();
    obs_psel = 0;
    obs_pen  = 0;
  endtask

  initial begin
    int a0;
    int r0;
    total = 0; bad = 0; acc_cnt = 0; acc_a = 0; cyc = 0;
    obs_rsp_cnt = 0; obs_rsp_cyc = 0; obs_psel = 0; obs_pen = 0;
    v_w = 0; v_prdata = 32'h0; v_err = 1'b0; v_srdy = 1'b0;
    idle();
    repeat (3) @(negedge PCLK);
    chk("rst_psel",      bus.PSEL1,     1'b0);
    chk("rst_penable",   bus.PENABLE,   1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_paddr",     bus.PADDR,     32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("ready_after_reset", bus.req_ready, 1'b1);

    // Write, ready on first ACCESS; PREADY also high in SETUP (must be ignored).
    clear_obs();
    send(1'b1, 32'h4, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b1);
    a0 = acc_a; idle(); wait_done();
    chk("t1_psel_cycles", obs_psel, 2);
    chk("t1_pen_cycles",  obs_pen, 1);
    chk("t1_latency",     obs_rsp_cyc - a0, 3);
    chk("t1_err",         obs_err, 1'b0);
    chk("t1_rdata",       obs_rdata, 32'h0);

    // Read with 3 wait states.
    clear_obs();
    send(1'b0, 32'h4, 32'h11111111, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    a0 = acc_a; idle(); wait_done();
    chk("t2_pen_cycles", obs_pen, 4);
    chk("t2_rdata",      obs_rdata, 32'hDEADBEEF);
    chk("t2_err",        obs_err, 1'b0);
    chk("t2_latency",    obs_rsp_cyc - a0, 6);

    // Read with slave error.
    clear_obs();
    send(1'b0, 32'h40, 32'h0, 1, 32'h12345678, 1'b1, 1'b0);
    idle(); wait_done();
    chk("t3_err",     obs_err, 1'b1);
    chk("t3_timeout", obs_to, 1'b0);
    chk("t3_rdata",   obs_rdata, 32'h12345678);

    // Hung slave: abort after 16 ACCESS cycles.
    clear_obs();
    send(1'b0, 32'h80, 32'h0, 100, 32'hCAFEF00D, 1'b0, 1'b0);
    a0 = acc_a; idle(); wait_done();
    chk("t4_pen_cycles", obs_pen, 16);
    chk("t4_timeout",    obs_to, 1'b1);
    chk("t4_err",        obs_err, 1'b1);
    chk("t4_rdata",      obs_rdata, 32'h0);
    chk("t4_latency",    obs_rsp_cyc - a0, 18);

    // Ready first rises on the 16th ACCESS cycle: completion wins.
    clear_obs();
    send(1'b0, 32'h84, 32'h0, 15, 32'h0BADCAFE, 1'b0, 1'b0);
    idle(); wait_done();
    chk("t5_pen_cycles", obs_pen, 16);
    chk("t5_timeout",    obs_to, 1'b0);
    chk("t5_err",        obs_err, 1'b0);
    chk("t5_rdata",      obs_rdata, 32'h0BADCAFE);

    // Four writes with req_valid held continuously.
    r0 = obs_rsp_cnt;
    send(1'b1, 32'h100, 32'hA0000001, 0, 32'h0, 1'b0, 1'b0);
    a0 = acc_a;
    send(1'b1, 32'h104, 32'hA0000002, 0, 32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h108, 32'hA0000003, 0, 32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h10C, 32'hA0000004, 0, 32'h0, 1'b0, 1'b0);
    idle(); wait_done();
    chk("t6_rsp_count", obs_rsp_cnt - r0, 4);
    chk("t6_span",      acc_a - a0, 9);

    // Asynchronous reset in the middle of ACCESS.
    send(1'b0, 32'hC0, 32'h0, 100, 32'h0, 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk("t7_psel_drop", bus.PSEL1,   1'b0);
    chk("t7_pen_drop",  bus.PENABLE, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    r0 = obs_rsp_cnt;
    repeat (25) @(negedge PCLK);
    chk("t7_no_rsp", obs_rsp_cnt - r0, 0);
    chk("t7_ready",  bus.req_ready, 1'b1);

    // Normal write after the reset.
    send(1'b1, 32'h8, 32'hA5A5A5A5, 2, 32'h0, 1'b0, 1'b0);
    idle(); wait_done();
    chk("t8_rsp_count", obs_rsp_cnt - r0, 1);
    chk("t8_err",       obs_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
